// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Inter-stage pipeline register (F/D, D/E, E/M, M/W) carrying a flat payload
//   plus a valid bit under hazard-unit stall/flush control. Tracks how many
//   consecutive cycles a valid entry has been held by a stall.
//
//   Edge priority: reset (i_reset = 0) > flush > stall > load.
//
// Optional feature macro: PIPE_STAGE_PERF_EN
//   When defined, adds saturating bubble (flush) and hold (valid stall)
//   performance counters. When undefined, o_bubble_cnt/o_hold_cnt read 0 and
//   the port list is unchanged.
//
// Ports
//   i_clk         clock, rising edge
//   i_reset       synchronous reset, active-low
//   i_stall       hold current contents
//   i_flush       insert a bubble on the next edge (beats i_stall)
//   i_valid_in    upstream stage holds a real instruction
//   i_data_in     upstream payload, DATA_W bits
//   o_valid_out   registered valid
//   o_data_out    registered payload
//   o_stall_cnt   consecutive cycles a valid entry has been held (saturating)
//   o_stall_sat   o_stall_cnt is all-ones
//   o_bubble_cnt  flushes taken (perf build only, else 0)
//   o_hold_cnt    stall cycles with o_valid_out = 1 (perf build only, else 0)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int unsigned        DATA_W      = 32,
    parameter int unsigned        CLEAR_DATA  = 1,
    parameter logic [DATA_W-1:0]  RESET_VAL   = '0,
    parameter int unsigned        STALL_CNT_W = 4,
    parameter int unsigned        PERF_CNT_W  = 32
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_stall,
    input  logic                   i_flush,
    input  logic                   i_valid_in,
    input  logic [DATA_W-1:0]      i_data_in,
    output logic                   o_valid_out,
    output logic [DATA_W-1:0]      o_data_out,
    output logic [STALL_CNT_W-1:0] o_stall_cnt,
    output logic                   o_stall_sat,
    output logic [PERF_CNT_W-1:0]  o_bubble_cnt,
    output logic [PERF_CNT_W-1:0]  o_hold_cnt
);

    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

    logic                   r_valid;
    logic [DATA_W-1:0]      r_data;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            // Reset always loads RESET_VAL, independent of CLEAR_DATA.
            r_valid     <= 1'b0;
            r_data      <= RESET_VAL;
            r_stall_cnt <= '0;
        end else if (i_flush) begin
            r_valid     <= 1'b0;
            if (CLEAR_DATA != 0) begin
                r_data <= RESET_VAL;
            end
            r_stall_cnt <= '0;
        end else if (i_stall) begin
            // Only a held valid entry ages; a stalled bubble keeps the count at 0.
            if (!r_valid) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != STALL_CNT_MAX) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end else begin
            // Payload is copied even for a bubble so the whole word moves together.
            r_valid     <= i_valid_in;
            r_data      <= i_data_in;
            r_stall_cnt <= '0;
        end
    end

    assign o_valid_out = r_valid;
    assign o_data_out  = r_data;
    assign o_stall_cnt = r_stall_cnt;
    assign o_stall_sat = (r_stall_cnt == STALL_CNT_MAX);

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [PERF_CNT_W-1:0] PERF_CNT_MAX = '1;

    logic [PERF_CNT_W-1:0] r_bubble_cnt;
    logic [PERF_CNT_W-1:0] r_hold_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_bubble_cnt <= '0;
            r_hold_cnt   <= '0;
        end else if (i_flush) begin
            // Flush+stall counts as a bubble only.
            if (r_bubble_cnt != PERF_CNT_MAX) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end else if (i_stall && r_valid) begin
            if (r_hold_cnt != PERF_CNT_MAX) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    assign o_bubble_cnt = r_bubble_cnt;
    assign o_hold_cnt   = r_hold_cnt;
`else
    assign o_bubble_cnt = '0;
    assign o_hold_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Two instances share one stimulus stream:
//     A: defaults (CLEAR_DATA=1, RESET_VAL=0, 4-bit stall count, 32-bit perf)
//     B: CLEAR_DATA=0, nonzero RESET_VAL, 3-bit stall count, 3-bit perf counters
//   A transaction-level model predicts every output; a negedge process compares
//   each cycle, and directed sequences pin the model with literal values.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam logic [31:0] RV_B = 32'hA5A5_0F0F;
`ifdef PIPE_STAGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, vin;
    logic [31:0] din;

    logic        a_valid, b_valid;
    logic [31:0] a_data, b_data;
    logic [3:0]  a_cnt;
    logic [2:0]  b_cnt;
    logic        a_sat, b_sat;
    logic [31:0] a_bub, a_hold;
    logic [2:0]  b_bub, b_hold;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W      (32),
        .CLEAR_DATA  (1),
        .RESET_VAL   (32'h0),
        .STALL_CNT_W (4),
        .PERF_CNT_W  (32)
    ) u_dut_a (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_stall      (stall),
        .i_flush      (flush),
        .i_valid_in   (vin),
        .i_data_in    (din),
        .o_valid_out  (a_valid),
        .o_data_out   (a_data),
        .o_stall_cnt  (a_cnt),
        .o_stall_sat  (a_sat),
        .o_bubble_cnt (a_bub),
        .o_hold_cnt   (a_hold)
    );

    pipe_stage_reg #(
        .DATA_W      (32),
        .CLEAR_DATA  (0),
        .RESET_VAL   (RV_B),
        .STALL_CNT_W (3),
        .PERF_CNT_W  (3)
    ) u_dut_b (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_stall      (stall),
        .i_flush      (flush),
        .i_valid_in   (vin),
        .i_data_in    (din),
        .o_valid_out  (b_valid),
        .o_data_out   (b_data),
        .o_stall_cnt  (b_cnt),
        .o_stall_sat  (b_sat),
        .o_bubble_cnt (b_bub),
        .o_hold_cnt   (b_hold)
    );

    // ---------------- behavioural model (index 0 = A, 1 = B) ----------------
    bit          m_clear [2] = '{1'b1, 1'b0};
    logic [31:0] m_rv    [2] = '{32'h0, RV_B};
    longint unsigned m_scmax [2] = '{64'd15, 64'd7};
    longint unsigned m_pcmax [2] = '{64'hFFFF_FFFF, 64'd7};

    bit              m_valid [2];
    logic [31:0]     m_data  [2];
    longint unsigned m_cnt   [2];
    longint unsigned m_bub   [2];
    longint unsigned m_hold  [2];

    function automatic longint unsigned sat_inc(input longint unsigned v,
                                                input longint unsigned mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_n === 1'b0) begin
                m_valid[i] = 1'b0;
                m_data[i]  = m_rv[i];
                m_cnt[i]   = 0;
                m_bub[i]   = 0;
                m_hold[i]  = 0;
            end else if (flush) begin
                m_valid[i] = 1'b0;
                if (m_clear[i]) m_data[i] = m_rv[i];
                m_cnt[i]   = 0;
                m_bub[i]   = sat_inc(m_bub[i], m_pcmax[i]);
            end else if (stall) begin
                if (m_valid[i]) begin
                    m_cnt[i]  = sat_inc(m_cnt[i], m_scmax[i]);
                    m_hold[i] = sat_inc(m_hold[i], m_pcmax[i]);
                end else begin
                    m_cnt[i] = 0;
                end
            end else begin
                m_valid[i] = vin;
                m_data[i]  = din;
                m_cnt[i]   = 0;
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("A.valid",  64'(a_valid), 64'(m_valid[0]));
            chk("A.data",   64'(a_data),  64'(m_data[0]));
            chk("A.cnt",    64'(a_cnt),   m_cnt[0]);
            chk("A.sat",    64'(a_sat),   64'(m_cnt[0] == m_scmax[0]));
            chk("A.bubble", 64'(a_bub),   PERF ? m_bub[0] : 64'd0);
            chk("A.hold",   64'(a_hold),  PERF ? m_hold[0] : 64'd0);
            chk("B.valid",  64'(b_valid), 64'(m_valid[1]));
            chk("B.data",   64'(b_data),  64'(m_data[1]));
            chk("B.cnt",    64'(b_cnt),   m_cnt[1]);
            chk("B.sat",    64'(b_sat),   64'(m_cnt[1] == m_scmax[1]));
            chk("B.bubble", 64'(b_bub),   PERF ? m_bub[1] : 64'd0);
            chk("B.hold",   64'(b_hold),  PERF ? m_hold[1] : 64'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, input logic s, input logic f, input logic v,
                         input logic [31:0] d);
        rst_n = r;
        stall = s;
        flush = f;
        vin   = v;
        din   = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        tick();
        chk_en = 1'b1;
        tick();
        chk("t1.A.valid", 64'(a_valid), 64'd0);
        chk("t1.A.data",  64'(a_data),  64'd0);
        chk("t1.B.data",  64'(b_data),  64'hA5A5_0F0F);
        chk("t1.A.sat",   64'(a_sat),   64'd0);

        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
        tick();
        chk("t2.A.valid", 64'(a_valid), 64'd1);
        chk("t2.A.data",  64'(a_data),  64'h1234_5678);

        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'($urandom), $urandom);
            tick();
        end
        chk("t3.A.data", 64'(a_data), 64'h1234_5678);
        chk("t3.A.cnt",  64'(a_cnt),  64'd15);
        chk("t3.A.sat",  64'(a_sat),  64'd1);
        chk("t3.B.cnt",  64'(b_cnt),  64'd7);

        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0BAD_F00D);
        tick();
        chk("t4.A.valid", 64'(a_valid), 64'd0);
        chk("t4.A.data",  64'(a_data),  64'd0);
        chk("t4.A.cnt",   64'(a_cnt),   64'd0);
        chk("t4.B.data",  64'(b_data),  64'h1234_5678);

        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hCAFE_0001);
        tick();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, $urandom);
            tick();
        end
        chk("t5.A.cnt7", 64'(a_cnt), 64'd7);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h5555_AAAA);
        tick();
        chk("t5.A.cnt",   64'(a_cnt),   64'd0);
        chk("t5.A.valid", 64'(a_valid), 64'd0);

        // Counters are zero after the reset above: 5 valid stalls, then 3 flushes.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h7777_0000);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, $urandom);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'($urandom), 1'b1, 1'b1, $urandom);
            tick();
        end
        chk("t6.A.bubble", 64'(a_bub),  PERF ? 64'd3 : 64'd0);
        chk("t6.A.hold",   64'(a_hold), PERF ? 64'd5 : 64'd0);
        chk("t6.B.bubble", 64'(b_bub),  PERF ? 64'd3 : 64'd0);

        // Random phase; stall-heavy so saturation and long holds occur.
        for (int i = 0; i < 1000; i++) begin
            drive(($urandom_range(0, 63) != 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0),
                  1'($urandom),
                  $urandom);
            tick();
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
